// File: rtl/sha256_ctrl_pkg.sv
// Shared types and defaults for the SHA-256 round controller.
// Optional abort input is enabled by defining SHA256_CTRL_ABORT_EN.
package sha256_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        SOC   = 3'd2,
        WAIT  = 3'd3,
        ROUND = 3'd4
    } state_e;

    localparam int ROUNDS_DEF      = 64;
    localparam int SCHED_WORDS_DEF = 16;

    function automatic int round_w(input int rounds);
        return (rounds > 1) ? $clog2(rounds) : 1;
    endfunction

endpackage

// File: rtl/sha256_round_cnt.sv
// Round index counter: synchronous clear, count enable, terminal count at ROUNDS-1.
module sha256_round_cnt
    import sha256_ctrl_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEF,
    parameter int RW     = round_w(ROUNDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == RW'(ROUNDS - 1));

    // Wrapping on tc keeps the index inside 0..ROUNDS-1 even if clr is late.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sha256_round_ctrl.sv
// Sequencer for the SHA-256 compression lanes: block intake, rounds, digest strobe.
// Define SHA256_CTRL_ABORT_EN to add the abort input (scrub lanes and return to IDLE).
module sha256_round_ctrl
    import sha256_ctrl_pkg::*;
#(
    parameter  int ROUNDS      = ROUNDS_DEF,
    parameter  int SCHED_WORDS = SCHED_WORDS_DEF,
    localparam int RW          = round_w(ROUNDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
`ifdef SHA256_CTRL_ABORT_EN
    input  logic          abort,
`endif
    input  logic          blk_valid,
    input  logic          blk_last,
    output logic          blk_ready,
    output logic          wvar_rst_n,
    output logic          soc,
    output logic          eoc,
    output logic [RW-1:0] round,
    output logic          w_sel_in,
    output logic          busy,
    output logic          digest_valid
);

    localparam logic [RW:0] SCHED_LIM = (RW + 1)'(SCHED_WORDS);

    state_e state, state_nxt;
    logic   last_q;
    logic   abort_act;
    logic   cnt_clr;
    logic   cnt_en;
    logic   cnt_tc;

`ifdef SHA256_CTRL_ABORT_EN
    assign abort_act = abort && (state != IDLE);
`else
    assign abort_act = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // last_q remembers whether the block now in flight closes the message.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (state == INIT) begin
            last_q <= 1'b0;
        end else if (state == WAIT && blk_valid && !abort_act) begin
            last_q <= blk_last;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort_act) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_nxt = INIT;
                INIT:    state_nxt = SOC;
                SOC:     state_nxt = last_q ? IDLE : WAIT;
                WAIT:    if (blk_valid) state_nxt = ROUND;
                ROUND:   if (cnt_tc) state_nxt = SOC;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The counter sits at 0 everywhere except while rounds are running.
    assign cnt_clr = (state_nxt != ROUND);
    assign cnt_en  = (state == ROUND);

    sha256_round_cnt #(
        .ROUNDS (ROUNDS),
        .RW     (RW)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .cnt (round),
        .tc  (cnt_tc)
    );

    always_comb begin
        blk_ready    = 1'b0;
        wvar_rst_n   = 1'b1;
        soc          = 1'b0;
        eoc          = 1'b0;
        w_sel_in     = 1'b0;
        busy         = 1'b1;
        digest_valid = 1'b0;
        case (state)
            IDLE: begin
                eoc  = 1'b1;
                busy = 1'b0;
            end
            INIT:  wvar_rst_n = 1'b0;
            SOC: begin
                soc          = 1'b1;
                digest_valid = last_q;
            end
            WAIT: begin
                eoc       = 1'b1;
                blk_ready = 1'b1;
            end
            ROUND: w_sel_in = ({1'b0, round} < SCHED_LIM);
            default: begin
                eoc  = 1'b1;
                busy = 1'b0;
            end
        endcase
        // An abort scrubs the lanes and suppresses any handshake or digest this cycle.
        if (abort_act) begin
            wvar_rst_n   = 1'b0;
            blk_ready    = 1'b0;
            digest_valid = 1'b0;
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: phase-level control model plus a SHA-256 lane model driven by the DUT.
// Abort stimulus is included when SHA256_CTRL_ABORT_EN is defined.
module tb_sha256_round_ctrl;

    localparam int ROUNDS = 64;
    localparam int SCHED  = 16;
    localparam int RW     = 6;

    localparam int P_IDLE  = 0;
    localparam int P_INIT  = 1;
    localparam int P_SOC   = 2;
    localparam int P_WAIT  = 3;
    localparam int P_ROUND = 4;

    logic          clk = 1'b0;
    logic          rst, start, blk_valid, blk_last, abort_i;
    logic          blk_ready, wvar_rst_n, soc, eoc, w_sel_in, busy, digest_valid;
    logic [RW-1:0] round;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    // phase-level reference
    int ph      = P_IDLE;
    int m_round = 0;
    bit m_last  = 1'b0;
    bit m_known = 1'b0;

    // lane model
    logic [31:0] acc [8];
    logic [31:0] wv  [8];
    logic [31:0] blk [16];
    logic [31:0] ws  [64];
    logic [31:0] dig0;
    int          n_dv   = 0;
    int          dv_cyc = 0;

    logic [31:0] H0 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    always #5 clk = ~clk;

    sha256_round_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
`ifdef SHA256_CTRL_ABORT_EN
        .abort        (abort_i),
`endif
        .blk_valid    (blk_valid),
        .blk_last     (blk_last),
        .blk_ready    (blk_ready),
        .wvar_rst_n   (wvar_rst_n),
        .soc          (soc),
        .eoc          (eoc),
        .round        (round),
        .w_sel_in     (w_sel_in),
        .busy         (busy),
        .digest_valid (digest_valid)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cycle);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] bs0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction
    function automatic logic [31:0] bs1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction
    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic bit abort_now();
`ifdef SHA256_CTRL_ABORT_EN
        return abort_i && (ph != P_IDLE);
`else
        return 1'b0;
`endif
    endfunction

    // Lanes react to the control lines the DUT presents during this cycle.
    task automatic lane_update();
        logic [31:0] w, t1, t2;
        int r;
        if (!wvar_rst_n) begin
            for (int i = 0; i < 8; i++) begin
                acc[i] = H0[i];
                wv[i]  = '0;
            end
        end else if (soc) begin
            for (int i = 0; i < 8; i++) begin
                wv[i]  = wv[i] + acc[i];
                acc[i] = wv[i];
            end
            if (digest_valid) begin
                dig0   = acc[0];
                n_dv++;
                dv_cyc = cycle;
            end
        end else if (!eoc) begin
            r = int'(round);
            if (w_sel_in)
                w = blk[r % 16];
            else if (r >= 16)
                w = ss1(ws[r-2]) + ws[r-7] + ss0(ws[r-15]) + ws[r-16];
            else
                w = '0;
            ws[r] = w;
            t1 = wv[7] + bs1(wv[4]) + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + K[r] + w;
            t2 = bs0(wv[0]) + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
            for (int i = 7; i > 0; i--) wv[i] = wv[i-1];
            wv[4] = wv[4] + t1;
            wv[0] = t1 + t2;
        end
    endtask

    task automatic model_update();
        bit ab;
        ab = abort_now();
        if (rst) begin
            ph = P_IDLE; m_round = 0; m_last = 1'b0; m_known = 1'b1;
        end else if (ab) begin
            ph = P_IDLE; m_round = 0;
        end else if (ph == P_IDLE) begin
            if (start) ph = P_INIT;
        end else if (ph == P_INIT) begin
            ph = P_SOC; m_last = 1'b0;
        end else if (ph == P_SOC) begin
            ph = m_last ? P_IDLE : P_WAIT;
        end else if (ph == P_WAIT) begin
            if (blk_valid) begin
                ph = P_ROUND; m_round = 0; m_last = blk_last;
            end
        end else begin
            if (m_round == ROUNDS - 1) begin
                ph = P_SOC; m_round = 0;
            end else begin
                m_round++;
            end
        end
    endtask

    // One clock: compare mid-cycle, feed lanes, take the edge, advance the model.
    task automatic cyc();
        bit ab;
        #2;
        if (m_known) begin
            ab = abort_now();
            chk("busy",         32'(busy),         32'(ph != P_IDLE));
            chk("blk_ready",    32'(blk_ready),    32'(ph == P_WAIT && !ab));
            chk("wvar_rst_n",   32'(wvar_rst_n),   32'(!(ph == P_INIT || ab)));
            chk("soc",          32'(soc),          32'(ph == P_SOC));
            chk("eoc",          32'(eoc),          32'(ph == P_IDLE || ph == P_WAIT));
            chk("round",        32'(round),        32'(m_round));
            chk("w_sel_in",     32'(w_sel_in),     32'(ph == P_ROUND && m_round < SCHED));
            chk("digest_valid", 32'(digest_valid), 32'(ph == P_SOC && m_last && !ab));
            lane_update();
        end
        @(posedge clk);
        model_update();
        #1;
        cycle++;
    endtask

    task automatic load_blk(input int id);
        for (int i = 0; i < 16; i++) begin
            case (id)
                0: blk[i] = (i == 0) ? 32'h61626380 : (i == 15) ? 32'h00000018 : 32'h0;
                1: blk[i] = (i == 14) ? 32'h80000000 : (i == 15) ? 32'h0 :
                            ((32'h61 + 32'(i)) << 24) | ((32'h62 + 32'(i)) << 16) |
                            ((32'h63 + 32'(i)) << 8)  |  (32'h64 + 32'(i));
                2: blk[i] = (i == 15) ? 32'h000001c0 : 32'h0;
                default: blk[i] = $urandom;
            endcase
        end
    endtask

    task automatic send_blk(input int id, input bit last, input int gap);
        int k;
        logic [31:0] a_hold;
        k = 0;
        while (ph != P_WAIT && k < 200) begin cyc(); k++; end
        if (ph != P_WAIT) chk("wait_timeout", 32'(ph), 32'(P_WAIT));
        a_hold = wv[0];
        for (int g = 0; g < gap; g++) begin
            cyc();
            chk("laneA_hold", wv[0], a_hold);
        end
        load_blk(id);
        blk_valid = 1'b1; blk_last = last;
        cyc();
        blk_valid = 1'b0; blk_last = 1'b0;
    endtask

    task automatic wait_dv(input int budget);
        int n0, k;
        n0 = n_dv; k = 0;
        while (n_dv == n0 && k < budget) begin cyc(); k++; end
        if (n_dv == n0) chk("dv_timeout", 32'(n_dv), 32'(n0 + 1));
    endtask

    task automatic run_abc(input string tag);
        int c0;
        c0 = cycle;
        start = 1'b1;
        cyc();
        start = 1'b0;
        send_blk(0, 1'b1, 0);
        wait_dv(150);
        chk({tag, "_lat"}, 32'(dv_cyc - c0), 32'd68);
        chk({tag, "_digest"}, dig0, 32'hba7816bf);
        cyc();
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n0, c0, k;
        bit sent;
        rst = 1'b1; start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; abort_i = 1'b0;
        for (int i = 0; i < 8; i++) begin acc[i] = '0; wv[i] = '0; end
        for (int i = 0; i < 64; i++) ws[i] = '0;
        load_blk(0);
        dig0 = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk("rst_eoc", 32'(eoc), 32'd1);
        chk("rst_wvar", 32'(wvar_rst_n), 32'd1);

        // single block "abc"
        run_abc("abc");

        // two blocks, 5-cycle wait between them
        n0 = n_dv;
        start = 1'b1; cyc(); start = 1'b0;
        send_blk(1, 1'b0, 0);
        send_blk(2, 1'b1, 5);
        wait_dv(150);
        cyc(); cyc();
        chk("two_blk_dv_count", 32'(n_dv - n0), 32'd1);
        chk("two_blk_digest", dig0, 32'h248d6a61);

        // stray start during rounds and stray blk_valid during SOC
        c0 = cycle; n0 = n_dv; sent = 1'b0; k = 0;
        start = 1'b1; cyc(); start = 1'b0;
        load_blk(0);
        while (n_dv == n0 && k < 200) begin
            start     = (ph == P_ROUND && m_round >= 20 && m_round <= 22);
            blk_valid = (ph == P_SOC) || (ph == P_WAIT && !sent);
            blk_last  = 1'b1;
            if (ph == P_WAIT) sent = 1'b1;
            cyc();
            k++;
        end
        start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
        chk("noise_lat", 32'(dv_cyc - c0), 32'd68);
        chk("noise_digest", dig0, 32'hba7816bf);
        cyc();

        // reset at round 30, then a clean message
        start = 1'b1; cyc(); start = 1'b0;
        send_blk(0, 1'b1, 0);
        k = 0;
        while (!(ph == P_ROUND && m_round == 30) && k < 100) begin cyc(); k++; end
        chk("reached_r30", 32'(round), 32'd30);
        rst = 1'b1; cyc(); rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_round", 32'(round), 32'd0);
        chk("midrst_eoc", 32'(eoc), 32'd1);
        chk("midrst_dv", 32'(digest_valid), 32'd0);
        run_abc("after_rst");

`ifdef SHA256_CTRL_ABORT_EN
        n0 = n_dv;
        start = 1'b1; cyc(); start = 1'b0;
        send_blk(0, 1'b1, 0);
        k = 0;
        while (!(ph == P_ROUND && m_round == 10) && k < 100) begin cyc(); k++; end
        abort_i = 1'b1; cyc(); abort_i = 1'b0;
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_scrub_acc", acc[0], H0[0]);
        chk("abort_scrub_a", wv[0], 32'h0);
        for (int i = 0; i < 80; i++) cyc();
        chk("abort_no_dv", 32'(n_dv - n0), 32'd0);
        abort_i = 1'b1; cyc(); cyc(); abort_i = 1'b0;
        chk("abort_idle_noop", 32'(busy), 32'd0);
        run_abc("after_abort");
`endif

        // randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            rst       = ($urandom % 400) == 0;
            start     = ($urandom % 8) == 0;
            blk_valid = ($urandom % 3) == 0;
            blk_last  = ($urandom % 2) == 0;
`ifdef SHA256_CTRL_ABORT_EN
            abort_i   = ($urandom % 150) == 0;
`endif
            if (blk_valid) load_blk(3);
            cyc();
        end
        start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0; abort_i = 1'b0;
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        run_abc("post_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
